// File: rtl/alu_exec_stage_pkg.sv
// Shared constants for the execute stage: ALU op encodings and flag bit layout.
package alu_exec_stage_pkg;

    typedef enum logic [2:0] {
        ALU_OP_ADD   = 3'd0,
        ALU_OP_SUB   = 3'd1,
        ALU_OP_AND   = 3'd2,
        ALU_OP_OR    = 3'd3,
        ALU_OP_XOR   = 3'd4,
        ALU_OP_SHL   = 3'd5,
        ALU_OP_SHR   = 3'd6,
        ALU_OP_PASSB = 3'd7
    } alu_op_e;

    localparam int unsigned FLAGS_W = 8;
    localparam int unsigned FLAG_Z  = 0;
    localparam int unsigned FLAG_N  = 1;
    localparam int unsigned FLAG_C  = 2;
    localparam int unsigned FLAG_V  = 3;
    localparam int unsigned FLAG_P  = 4;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result plus zero/negative/carry/overflow/parity flags.
module alu
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [2:0]         op,
    input  logic [DW-1:0]      a,
    input  logic [DW-1:0]      b,
    output logic [DW-1:0]      result,
    output logic [FLAGS_W-1:0] flags
);

    logic [DW:0] ext;
    logic        carry;
    logic        ovf;

    // SUB reports borrow in carry: the extended difference sets its top bit when a < b.
    always_comb begin
        ext    = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (alu_op_e'(op))
            ALU_OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[DW-1:0];
                carry  = ext[DW];
                ovf    = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            ALU_OP_SUB: begin
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[DW-1:0];
                carry  = ext[DW];
                ovf    = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            ALU_OP_AND:   result = a & b;
            ALU_OP_OR:    result = a | b;
            ALU_OP_XOR:   result = a ^ b;
            ALU_OP_SHL: begin
                result = {a[DW-2:0], 1'b0};
                carry  = a[DW-1];
            end
            ALU_OP_SHR: begin
                result = {1'b0, a[DW-1:1]};
                carry  = a[0];
            end
            ALU_OP_PASSB: result = b;
            default:      result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[DW-1];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
        flags[FLAG_P] = ^result;
    end

endmodule

// File: rtl/alu_exec_stage_slot.sv
// One buffered result entry (result, dst, wb_en, flags); used for both output and skid slots.
module exec_slot
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DW-1:0]      d_result,
    input  logic [RW-1:0]      d_dst,
    input  logic               d_wb_en,
    input  logic [FLAGS_W-1:0] d_flags,
    output logic [DW-1:0]      q_result,
    output logic [RW-1:0]      q_dst,
    output logic               q_wb_en,
    output logic [FLAGS_W-1:0] q_flags
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_result <= '0;
            q_dst    <= '0;
            q_wb_en  <= 1'b0;
            q_flags  <= '0;
        end else if (load) begin
            q_result <= d_result;
            q_dst    <= d_dst;
            q_wb_en  <= d_wb_en;
            q_flags  <= d_flags;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU + registered output slot with one-entry skid buffer,
// architectural flags register and retired-instruction counter.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 3,
    parameter int unsigned CW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [DW-1:0]      in_a,
    input  logic [DW-1:0]      in_b,
    input  logic [RW-1:0]      in_dst,
    input  logic               in_wb_en,
    input  logic               in_flags_we,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_result,
    output logic [RW-1:0]      out_dst,
    output logic               out_wb_en,
    output logic [7:0]         out_flags,
    output logic [7:0]         arch_flags,
    output logic [CW-1:0]      retired_count
);

    logic               skid_valid;
    logic [DW-1:0]      alu_result;
    logic [FLAGS_W-1:0] alu_flags;
    logic [FLAGS_W-1:0] new_flags;
    logic               accept;
    logic               drain;

    logic [DW-1:0]      skid_result;
    logic [RW-1:0]      skid_dst;
    logic               skid_wb_en;
    logic [FLAGS_W-1:0] skid_flags;

    logic               out_load;
    logic               out_from_skid;
    logic               skid_load;
    logic               out_valid_n;
    logic               skid_valid_n;

    logic [DW-1:0]      out_d_result;
    logic [RW-1:0]      out_d_dst;
    logic               out_d_wb_en;
    logic [FLAGS_W-1:0] out_d_flags;

    alu #(.DW(DW)) u_alu (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign in_ready = !skid_valid && !rst;
    assign accept   = in_valid && in_ready && !flush;
    assign drain    = out_valid && out_ready;

    // arch_flags already reflects every older accepted instruction.
    assign new_flags = in_flags_we ? alu_flags : arch_flags;

    always_comb begin
        out_load      = 1'b0;
        out_from_skid = 1'b0;
        skid_load     = 1'b0;
        out_valid_n   = out_valid;
        skid_valid_n  = skid_valid;
        if (drain && skid_valid) begin
            out_load      = 1'b1;
            out_from_skid = 1'b1;
            skid_load     = accept;
            skid_valid_n  = accept;
            out_valid_n   = 1'b1;
        end else if (drain || !out_valid) begin
            out_load    = accept;
            out_valid_n = accept;
        end else begin
            skid_load = accept;
            if (accept) begin
                skid_valid_n = 1'b1;
            end
        end
        if (flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end
    end

    assign out_d_result = out_from_skid ? skid_result : alu_result;
    assign out_d_dst    = out_from_skid ? skid_dst    : in_dst;
    assign out_d_wb_en  = out_from_skid ? skid_wb_en  : in_wb_en;
    assign out_d_flags  = out_from_skid ? skid_flags  : new_flags;

    exec_slot #(.DW(DW), .RW(RW)) u_out_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (out_load),
        .d_result (out_d_result),
        .d_dst    (out_d_dst),
        .d_wb_en  (out_d_wb_en),
        .d_flags  (out_d_flags),
        .q_result (out_result),
        .q_dst    (out_dst),
        .q_wb_en  (out_wb_en),
        .q_flags  (out_flags)
    );

    exec_slot #(.DW(DW), .RW(RW)) u_skid_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .d_result (alu_result),
        .d_dst    (in_dst),
        .d_wb_en  (in_wb_en),
        .d_flags  (new_flags),
        .q_result (skid_result),
        .q_dst    (skid_dst),
        .q_wb_en  (skid_wb_en),
        .q_flags  (skid_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            skid_valid    <= 1'b0;
            arch_flags    <= '0;
            retired_count <= '0;
        end else begin
            out_valid  <= out_valid_n;
            skid_valid <= skid_valid_n;
            if (accept && in_flags_we) begin
                arch_flags <= alu_flags;
            end
            if (drain) begin
                retired_count <= retired_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: driver pushes expected entries, monitor pops on drain.
module tb_alu_exec_stage;
    import alu_exec_stage_pkg::*;

    localparam int DW = 8;
    localparam int RW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [RW-1:0] in_dst = '0;
    logic          in_wb_en = 1'b0;
    logic          in_flags_we = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_dst;
    logic          out_wb_en;
    logic [7:0]    out_flags;
    logic [7:0]    arch_flags;
    logic [CW-1:0] retired_count;

    alu_exec_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_dst        (in_dst),
        .in_wb_en      (in_wb_en),
        .in_flags_we   (in_flags_we),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_dst       (out_dst),
        .out_wb_en     (out_wb_en),
        .out_flags     (out_flags),
        .arch_flags    (arch_flags),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] result;
        logic [2:0] dst;
        logic       wb_en;
        logic [7:0] flags;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         acc_now = 0;
    int         retired_m = 0;
    logic [7:0] arch_m = '0;
    logic [7:0] arch_before = '0;
    logic       accepted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from plain integer arithmetic; returns {flags, result}.
    function automatic logic [15:0] ref_alu(input int op, input int a, input int b);
        int r = 0;
        int c = 0;
        int v = 0;
        logic [7:0] rb;
        logic [7:0] f;
        case (op)
            0: begin
                r = (a + b) % 256;
                c = (a + b > 255) ? 1 : 0;
                v = ((a < 128) == (b < 128) && (r < 128) != (a < 128)) ? 1 : 0;
            end
            1: begin
                r = (a - b + 256) % 256;
                c = (a < b) ? 1 : 0;
                v = ((a < 128) != (b < 128) && (r < 128) != (a < 128)) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            6: begin r = a / 2; c = a % 2; end
            default: r = b;
        endcase
        rb = r[7:0];
        f = '0;
        f[FLAG_Z] = (r == 0);
        f[FLAG_N] = (r >= 128);
        f[FLAG_C] = (c != 0);
        f[FLAG_V] = (v != 0);
        f[FLAG_P] = ($countones(rb) % 2) == 1;
        return {f, rb};
    endfunction

    // Inputs are set just after a negedge; this resolves the handshake and waits for the next negedge.
    task automatic cycle();
        exp_t        e;
        logic [15:0] r;
        #1;
        if (rst) chk("in_ready_in_reset", in_ready, 0);
        accepted = in_valid && in_ready && !flush && !rst;
        acc_now = accepted ? 1 : 0;
        arch_before = arch_m;
        if (accepted) begin
            r = ref_alu(int'(in_op), int'(in_a), int'(in_b));
            e.result = r[7:0];
            e.dst = in_dst;
            e.wb_en = in_wb_en;
            e.flags = in_flags_we ? r[15:8] : arch_m;
            sb.push_back(e);
            if (in_flags_we) arch_m = r[15:8];
        end
        if (rst) begin
            sb.delete();
            retired_m = 0;
            arch_m = '0;
            arch_before = '0;
        end
        @(negedge clk);
    endtask

    task automatic set_in(input int op, input int a, input int b, input int dst, input bit wb, input bit fwe);
        in_valid = 1'b1;
        in_op = op[2:0];
        in_a = a[7:0];
        in_b = b[7:0];
        in_dst = dst[2:0];
        in_wb_en = wb;
        in_flags_we = fwe;
    endtask

    task automatic send(input int op, input int a, input int b, input int dst, input bit wb, input bit fwe);
        set_in(op, a, b, dst, wb, fwe);
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept within 40 cycles");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic zero_check();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_dst", out_dst, 0);
        chk("rst_out_wb_en", out_wb_en, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_arch_flags", arch_flags, 0);
        chk("rst_retired", retired_count, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    // Monitor: compares DUT state against the model once per cycle, pops on drain.
    initial begin
        int nbuf;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                nbuf = sb.size() - acc_now;
                chk("out_valid", out_valid, (nbuf != 0) ? 1 : 0);
                chk("in_ready", in_ready, (nbuf < 2) ? 1 : 0);
                chk("arch_flags", arch_flags, arch_before);
                chk("retired_count", retired_count, retired_m & 15);
                if (nbuf > 0) begin
                    chk("out_result", out_result, sb[0].result);
                    chk("out_dst", out_dst, sb[0].dst);
                    chk("out_wb_en", out_wb_en, sb[0].wb_en);
                    chk("out_flags", out_flags, sb[0].flags);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        retired_m++;
                    end
                end
                if (flush) sb.delete();
            end
        end
    end

    initial begin
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        zero_check();

        // single ADD 100+28: N and V set
        out_ready = 1'b1;
        send(ALU_OP_ADD, 100, 28, 3, 1'b1, 1'b1);
        idle(2);

        // backpressure: two accepted, third held upstream
        out_ready = 1'b0;
        send(ALU_OP_ADD, 1, 1, 1, 1'b1, 1'b1);
        send(ALU_OP_ADD, 2, 2, 2, 1'b1, 1'b1);
        set_in(ALU_OP_ADD, 3, 3, 4, 1'b1, 1'b1);
        repeat (3) begin
            cycle();
            chk("bp_third_held", accepted, 0);
        end
        out_ready = 1'b1;
        send(ALU_OP_ADD, 3, 3, 4, 1'b1, 1'b1);
        idle(4);

        // flags_we=0 inherits the running flags
        send(ALU_OP_ADD, 255, 1, 5, 1'b1, 1'b1);
        send(ALU_OP_ADD, 1, 1, 6, 1'b1, 1'b0);
        idle(3);

        // streaming
        for (int i = 0; i < 20; i++) begin
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 i % 8, 1'b1, 1'b1);
            chk("stream_no_stall", accepted, 1);
        end
        idle(3);

        // flush with both slots full and a same-cycle in_valid
        out_ready = 1'b0;
        send(ALU_OP_SUB, 5, 9, 1, 1'b1, 1'b1);
        send(ALU_OP_XOR, 170, 85, 2, 1'b0, 1'b1);
        set_in(ALU_OP_ADD, 7, 7, 3, 1'b1, 1'b1);
        flush = 1'b1;
        cycle();
        chk("flush_no_accept", accepted, 0);
        flush = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // randomized traffic with occasional flush
        for (int i = 0; i < 250; i++) begin
            set_in(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 39) == 0);
            cycle();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // reset with both slots full
        out_ready = 1'b0;
        send(ALU_OP_SHL, 200, 0, 7, 1'b1, 1'b1);
        send(ALU_OP_SHR, 3, 0, 6, 1'b1, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        zero_check();
        out_ready = 1'b1;
        idle(3);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
